// File: rtl/poc_pkg.sv
// poc_pkg: shared widths and FSM encoding for the ALU arbiter slice.
//   DATA_W : default ALU operand/result width
//   SEL_W  : default ALU opcode width
//   CNT_W  : latency counter width (ALU_LAT up to 15)
//   state_t: IDLE -> BUSY -> RESP; encoding 2'd3 is unused and recovers to IDLE
package poc_pkg;
    localparam int DATA_W = 18;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 4;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;
endpackage

// File: rtl/poc_alu_arbiter_if.sv
// poc_alu_arbiter_if: bundles the two-requester handshake, the shared result
// bus and the external ALU drive/return signals.
//   master : requesters + ALU model (drives requests, rsp_ready, ALU result)
//   slave  : the arbiter itself
interface poc_alu_arbiter_if #(
    parameter int DATA_W = poc_pkg::DATA_W,
    parameter int SEL_W  = poc_pkg::SEL_W
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*SEL_W-1:0]  req_sel;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_c;
    logic                rsp_lsb;
    logic                rsp_neg;
    logic [SEL_W-1:0]    alu_sel;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_c;
    logic                alu_lsb;
    logic                alu_neg;
    logic                busy;
    logic                grant_id;

    modport master (
        output req_valid, req_sel, req_a, req_b, rsp_ready, alu_c, alu_lsb, alu_neg,
        input  req_ready, rsp_valid, rsp_c, rsp_lsb, rsp_neg, alu_sel, alu_a, alu_b,
        input  busy, grant_id
    );

    modport slave (
        input  req_valid, req_sel, req_a, req_b, rsp_ready, alu_c, alu_lsb, alu_neg,
        output req_ready, rsp_valid, rsp_c, rsp_lsb, rsp_neg, alu_sel, alu_a, alu_b,
        output busy, grant_id
    );
endinterface

// File: rtl/poc_rr_arb2.sv
// poc_rr_arb2: combinational 2-way round-robin pick.
//   req_valid   : request bits
//   last        : index granted most recently
//   grant_valid : at least one request present
//   winner      : chosen index; on contention the one that did not win last
module poc_rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last,
    output logic       grant_valid,
    output logic       winner
);
    assign grant_valid = |req_valid;
    assign winner      = (&req_valid) ? ~last : req_valid[1];
endmodule

// File: rtl/poc_alu_arbiter.sv
// poc_alu_arbiter: shares one external ALU between two requesters.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request handshake, shared registered result, ALU drive/return
// One operation is in flight at a time: accept in IDLE, wait ALU_LAT+1 edges
// in BUSY, then hold the captured result in RESP until the owner takes it.
module poc_alu_arbiter #(
    parameter int DATA_W  = poc_pkg::DATA_W,
    parameter int SEL_W   = poc_pkg::SEL_W,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    poc_alu_arbiter_if.slave      bus
);
    import poc_pkg::*;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              gid;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] c_q;
    logic              lsb_q;
    logic              neg_q;

    logic              win_vld;
    logic              win;
    logic [1:0]        ready;
    logic [1:0]        rv;
    logic              accept;
    logic              rsp_done;

    poc_rr_arb2 u_arb (
        .req_valid   (bus.req_valid),
        .last        (last),
        .grant_valid (win_vld),
        .winner      (win)
    );

    // Ready is withheld while rst is high so nothing looks accepted in reset.
    always_comb begin
        ready = '0;
        if (state == IDLE && !rst && win_vld)
            ready[win] = 1'b1;
    end

    always_comb begin
        rv = '0;
        if (state == RESP)
            rv[gid] = 1'b1;
    end

    assign accept   = |(bus.req_valid & ready);
    // Only the owner's rsp_ready counts; the other index is ignored.
    assign rsp_done = (state == RESP) && bus.rsp_ready[gid];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            gid   <= 1'b0;
            sel_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            lsb_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sel_q <= win ? bus.req_sel[SEL_W +: SEL_W] : bus.req_sel[0 +: SEL_W];
                    a_q   <= win ? bus.req_a[DATA_W +: DATA_W] : bus.req_a[0 +: DATA_W];
                    b_q   <= win ? bus.req_b[DATA_W +: DATA_W] : bus.req_b[0 +: DATA_W];
                    gid   <= win;
                    last  <= win;
                    cnt   <= CNT_W'(ALU_LAT);
                    state <= BUSY;
                end
                // cnt reaching zero marks the ALU output as settled
                BUSY: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    c_q   <= bus.alu_c;
                    lsb_q <= bus.alu_lsb;
                    neg_q <= bus.alu_neg;
                    state <= RESP;
                end
                // Returning to IDLE here (not re-arbitrating) enforces one
                // idle cycle between a handshake and the next acceptance.
                RESP: if (rsp_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rv;
    assign bus.rsp_c     = c_q;
    assign bus.rsp_lsb   = lsb_q;
    assign bus.rsp_neg   = neg_q;
    assign bus.alu_sel   = sel_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = gid;
endmodule

// File: tb/tb_poc_alu_arbiter.sv
module tb_poc_alu_arbiter;
    localparam int DATA_W  = 18;
    localparam int SEL_W   = 4;
    localparam int ALU_LAT = 1;

    typedef struct {
        bit               id;
        logic [SEL_W-1:0] sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        bit               lsb;
        bit               neg;
    } vec_t;

    typedef struct {
        bit                id;
        logic [DATA_W-1:0] c;
        bit                lsb;
        bit                neg;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poc_alu_arbiter_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    poc_alu_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W), .ALU_LAT(ALU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU: sel 1 = add, sel 2 = subtract, else 0.
    assign bus.alu_c   = (bus.alu_sel == 4'd1) ? bus.alu_a + bus.alu_b :
                         (bus.alu_sel == 4'd2) ? bus.alu_a - bus.alu_b : '0;
    assign bus.alu_lsb = bus.alu_c[0];
    assign bus.alu_neg = bus.alu_c[DATA_W-1];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_n = 0;
    int   acc_cyc = 0;
    int   rsp_n = 0;
    int   fair_n = 0;
    bit   fair_mode = 0;
    logic [1:0] prev_rv = '0;
    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d req=%0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: acceptance timing, response latency, scoreboard compare.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (|(bus.req_valid & bus.req_ready)) begin
                if (fair_mode && fair_n > 0) chk("fair_interval", cyc - acc_cyc, ALU_LAT + 3);
                if (fair_mode) fair_n++;
                acc_cyc = cyc;
                acc_n++;
            end
            // accept sampled one edge before it happens, hence +2
            if (bus.rsp_valid != 2'b00 && prev_rv == 2'b00)
                chk("rsp_latency", cyc - acc_cyc, ALU_LAT + 2);
            if (|(bus.rsp_valid & bus.rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid_id", int'(bus.rsp_valid), 1 << e.id);
                    chk("grant_id", int'(bus.grant_id), int'(e.id));
                    chk("rsp_c", int'(bus.rsp_c), int'(e.c));
                    chk("rsp_lsb", int'(bus.rsp_lsb), int'(e.lsb));
                    chk("rsp_neg", int'(bus.rsp_neg), int'(e.neg));
                end
                rsp_n++;
            end
        end
        prev_rv = bus.rsp_valid;
    end

    task automatic drive(input bit id, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b);
        bus.req_sel[SEL_W*id +: SEL_W]   = s;
        bus.req_a[DATA_W*id +: DATA_W]   = a;
        bus.req_b[DATA_W*id +: DATA_W]   = b;
        bus.req_valid[id]                = 1'b1;
    endtask

    task automatic push(input bit id, input logic [DATA_W-1:0] c, input bit lsb, input bit neg);
        exp_t e;
        e.id = id; e.c = c; e.lsb = lsb; e.neg = neg;
        sb.push_back(e);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_n < target && n < budget) begin @(posedge clk); n++; end
        #1;
        if (acc_n < target) chk("timeout_accept", acc_n, target);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (rsp_n < target && n < budget) begin @(posedge clk); n++; end
        #1;
        if (rsp_n < target) chk("timeout_rsp", rsp_n, target);
    endtask

    vec_t vt[6];

    initial begin
        int base;
        // 18-bit sums: 131071+1 = 131072 sets bit 17; 262143+1 wraps to 0.
        vt[0] = '{0, 4'd1, 18'd6,      18'd4,     18'd10,     1'b0, 1'b0};
        vt[1] = '{1, 4'd1, 18'd0,      18'd66822, 18'd66822,  1'b0, 1'b0};
        vt[2] = '{0, 4'd1, 18'd262143, 18'd1,     18'd0,      1'b0, 1'b0};
        vt[3] = '{1, 4'd1, 18'd131072, 18'd0,     18'd131072, 1'b0, 1'b1};
        vt[4] = '{0, 4'd1, 18'd131071, 18'd1,     18'd131072, 1'b0, 1'b1};
        vt[5] = '{1, 4'd2, 18'd5,      18'd7,     18'd262142, 1'b0, 1'b1};

        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_sel = '0; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_alu_a", int'(bus.alu_a), 0);
        chk("rst_rsp_c", int'(bus.rsp_c), 0);
        chk("rst_grant_id", int'(bus.grant_id), 0);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous requests: requester 0 favoured first after reset.
        bus.rsp_ready = 2'b11;
        drive(0, 4'd1, 18'd6, 18'd4);
        drive(1, 4'd1, 18'd0, 18'd66822);
        push(0, 18'd10, 0, 0);
        push(1, 18'd66822, 0, 0);
        #1 chk("simul_ready", int'(bus.req_ready), 1);
        wait_acc(1, 10);
        bus.req_valid[0] = 1'b0;
        chk("simul_gid0", int'(bus.grant_id), 0);
        chk("simul_alu_a", int'(bus.alu_a), 6);
        chk("simul_alu_b", int'(bus.alu_b), 4);
        chk("simul_busy", int'(bus.busy), 1);
        chk("simul_busy_ready", int'(bus.req_ready), 0);
        wait_acc(2, 10);
        bus.req_valid[1] = 1'b0;
        chk("simul_gid1", int'(bus.grant_id), 1);
        chk("simul_alu_b1", int'(bus.alu_b), 66822);
        wait_rsp(2, 10);

        // Table-driven single operations.
        for (int i = 0; i < 6; i++) begin
            base = acc_n;
            drive(vt[i].id, vt[i].sel, vt[i].a, vt[i].b);
            push(vt[i].id, vt[i].c, vt[i].lsb, vt[i].neg);
            #1 chk("vec_ready", int'(bus.req_ready), 1 << vt[i].id);
            wait_acc(base + 1, 10);
            bus.req_valid = 2'b00;
            chk("vec_alu_sel", int'(bus.alu_sel), int'(vt[i].sel));
            chk("vec_alu_a", int'(bus.alu_a), int'(vt[i].a));
            chk("vec_alu_b", int'(bus.alu_b), int'(vt[i].b));
            wait_rsp(rsp_n + 1, 10);
        end

        // Backpressure: result held while owner stalls; pending req1 waits.
        bus.rsp_ready = 2'b00;
        base = acc_n;
        drive(0, 4'd1, 18'd100, 18'd23);
        push(0, 18'd123, 1, 0);
        wait_acc(base + 1, 10);
        bus.req_valid[0] = 1'b0;
        drive(1, 4'd1, 18'd7, 18'd8);
        push(1, 18'd15, 1, 0);
        for (int n = 0; n < 10 && bus.rsp_valid == 2'b00; n++) begin @(posedge clk); #1; end
        for (int n = 0; n < 5; n++) begin
            if (n == 2) bus.rsp_ready = 2'b10;
            #1;
            chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
            chk("bp_rsp_c", int'(bus.rsp_c), 123);
            chk("bp_req_ready", int'(bus.req_ready), 0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 2'b01;
        #1 chk("bp_hs_ready", int'(bus.req_ready), 0);
        @(posedge clk); #1;
        chk("bp_after_ready", int'(bus.req_ready), 2);
        chk("bp_after_rsp_valid", int'(bus.rsp_valid), 0);
        chk("bp_rsp_c_kept", int'(bus.rsp_c), 123);
        bus.rsp_ready = 2'b11;
        wait_acc(base + 2, 10);
        bus.req_valid = 2'b00;
        wait_rsp(rsp_n + 1, 10);

        // Reset mid-BUSY: in-flight op is dropped, no push for it.
        base = acc_n;
        drive(0, 4'd1, 18'd5, 18'd5);
        wait_acc(base + 1, 10);
        bus.req_valid = 2'b00;
        base = rsp_n;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("mid_rst_alu_a", int'(bus.alu_a), 0);
        chk("mid_rst_alu_sel", int'(bus.alu_sel), 0);
        chk("mid_rst_rsp_c", int'(bus.rsp_c), 0);
        chk("mid_rst_gid", int'(bus.grant_id), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 4'd1, 18'd3, 18'd4);
        push(1, 18'd7, 1, 0);
        #1 chk("post_rst_ready", int'(bus.req_ready), 2);
        chk("post_rst_no_rsp", rsp_n, base);
        base = acc_n;
        @(posedge clk); #1;
        chk("post_rst_accept", acc_n, base + 1);
        bus.req_valid = 2'b00;
        wait_rsp(rsp_n + 1, 10);

        // Fairness: both continuously valid, grants alternate 0,1,...
        base = acc_n;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) push(0, 18'd3, 1, 0);
            else            push(1, 18'd30, 0, 0);
        end
        fair_mode = 1'b1;
        drive(0, 4'd1, 18'd1, 18'd2);
        drive(1, 4'd1, 18'd10, 18'd20);
        wait_acc(base + 8, 60);
        bus.req_valid = 2'b00;
        fair_mode = 1'b0;
        chk("fair_count", fair_n, 8);
        wait_rsp(rsp_n + (sb.size()), 20);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d req=%0d", cyc, 0);
        $fatal(1, "timeout");
    end
endmodule
